// File: rtl/demod_branch_merge.sv
// demod_branch_merge: joins the if-branch result, the else-branch result and the
// branch condition. Each arrives on its own valid/ready stream with its own FIFO.
// Heads are popped only as aligned triples. The condition picks which branch's
// NCH-channel result goes out on a registered valid/ready port.
// Optional build macro: DEMOD_MERGE_STATS_EN. It adds per-branch selection counters
// and a synchronous clear for them.

module demod_branch_merge_fifo #(
    parameter int W     = 32,
    parameter int DEPTH = 4
) (
    input  logic         clk,
    input  logic         reset,
    input  logic         push,
    input  logic [W-1:0] wdata,
    input  logic         pop,
    output logic [W-1:0] rdata,
    output logic         empty,
    output logic         full
);
    localparam int AW = $clog2(DEPTH);
    localparam int CW = $clog2(DEPTH + 1);

    logic [W-1:0]  mem [DEPTH];
    logic [AW-1:0] wr_ptr, rd_ptr;
    logic [CW-1:0] count;

    assign empty = (count == '0);
    assign full  = (count == CW'(DEPTH));
    assign rdata = mem[rd_ptr];

    // storage write; contents need no reset because count gates visibility
    always_ff @(posedge clk) begin
        if (push) mem[wr_ptr] <= wdata;
    end

    // pointers wrap naturally since DEPTH is a power of 2
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            if (push) wr_ptr <= wr_ptr + 1'b1;
            if (pop)  rd_ptr <= rd_ptr + 1'b1;
            case ({push, pop})
                2'b10:   count <= count + 1'b1;
                2'b01:   count <= count - 1'b1;
                default: count <= count;
            endcase
        end
    end
endmodule

module demod_branch_merge #(
    parameter int WIDTH = 32,
    parameter int NCH   = 2,
    parameter int DEPTH = 4
) (
    input  logic                 clk,
    input  logic                 reset,
    input  logic                 if_valid,
    input  logic [NCH*WIDTH-1:0] if_data,
    output logic                 if_ready,
    input  logic                 else_valid,
    input  logic [NCH*WIDTH-1:0] else_data,
    output logic                 else_ready,
    input  logic                 cond_valid,
    input  logic                 cond_in,
    output logic                 cond_ready,
    output logic                 out_valid,
    input  logic                 out_ready,
    output logic [NCH*WIDTH-1:0] out_data,
    output logic                 out_cond
`ifdef DEMOD_MERGE_STATS_EN
    ,
    input  logic                 stat_clr,
    output logic [15:0]          stat_if_cnt,
    output logic [15:0]          stat_else_cnt
`endif
);
    localparam int DW = NCH * WIDTH;

    logic [DW-1:0] if_head, else_head, sel_data;
    logic          cond_head;
    logic          if_empty, else_empty, cond_empty;
    logic          if_full, else_full, cond_full;
    logic          fire;

    // ready is held low during reset and never bypasses a full FIFO
    assign if_ready   = !reset && !if_full;
    assign else_ready = !reset && !else_full;
    assign cond_ready = !reset && !cond_full;

    assign fire = !if_empty && !else_empty && !cond_empty && (!out_valid || out_ready);

    demod_branch_merge_fifo #(.W(DW), .DEPTH(DEPTH)) u_if_fifo (
        .clk(clk), .reset(reset), .push(if_valid && if_ready), .wdata(if_data),
        .pop(fire), .rdata(if_head), .empty(if_empty), .full(if_full)
    );

    demod_branch_merge_fifo #(.W(DW), .DEPTH(DEPTH)) u_else_fifo (
        .clk(clk), .reset(reset), .push(else_valid && else_ready), .wdata(else_data),
        .pop(fire), .rdata(else_head), .empty(else_empty), .full(else_full)
    );

    demod_branch_merge_fifo #(.W(1), .DEPTH(DEPTH)) u_cond_fifo (
        .clk(clk), .reset(reset), .push(cond_valid && cond_ready), .wdata(cond_in),
        .pop(fire), .rdata(cond_head), .empty(cond_empty), .full(cond_full)
    );

    // per-channel select between branch results
    for (genvar k = 0; k < NCH; k++) begin : g_ch
        assign sel_data[k*WIDTH +: WIDTH] = cond_head ? if_head[k*WIDTH +: WIDTH]
                                                      : else_head[k*WIDTH +: WIDTH];
    end

    // output register: load on fire, clear valid once consumed, hold while stalled
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            out_valid <= 1'b0;
            out_data  <= '0;
            out_cond  <= 1'b0;
        end else if (fire) begin
            out_valid <= 1'b1;
            out_data  <= sel_data;
            out_cond  <= cond_head;
        end else if (out_valid && out_ready) begin
            out_valid <= 1'b0;
        end
    end

`ifdef DEMOD_MERGE_STATS_EN
    // saturating selection counters; clear beats a same-cycle increment
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            stat_if_cnt   <= '0;
            stat_else_cnt <= '0;
        end else if (stat_clr) begin
            stat_if_cnt   <= '0;
            stat_else_cnt <= '0;
        end else if (fire) begin
            if (cond_head && stat_if_cnt != 16'hFFFF)
                stat_if_cnt <= stat_if_cnt + 16'd1;
            if (!cond_head && stat_else_cnt != 16'hFFFF)
                stat_else_cnt <= stat_else_cnt + 16'd1;
        end
    end
`endif
endmodule

// File: tb/tb_demod_branch_merge.sv
// Directed bench for demod_branch_merge: reset, select, skew, back-pressure,
// reset mid-stream, and (with DEMOD_MERGE_STATS_EN) the selection counters.
module tb_demod_branch_merge;
    localparam int WIDTH = 32;
    localparam int NCH   = 2;
    localparam int DEPTH = 4;
    localparam int DW    = NCH * WIDTH;

    logic          clk = 1'b0;
    logic          reset = 1'b1;
    logic          if_valid = 1'b0, else_valid = 1'b0, cond_valid = 1'b0;
    logic [DW-1:0] if_data = '0, else_data = '0;
    logic          cond_in = 1'b0;
    logic          if_ready, else_ready, cond_ready;
    logic          out_valid;
    logic          out_ready = 1'b0;
    logic [DW-1:0] out_data;
    logic          out_cond;
`ifdef DEMOD_MERGE_STATS_EN
    logic          stat_clr = 1'b0;
    logic [15:0]   stat_if_cnt, stat_else_cnt;
`endif

    int n_chk = 0;
    int n_err = 0;

    demod_branch_merge #(.WIDTH(WIDTH), .NCH(NCH), .DEPTH(DEPTH)) dut (
        .clk(clk), .reset(reset),
        .if_valid(if_valid), .if_data(if_data), .if_ready(if_ready),
        .else_valid(else_valid), .else_data(else_data), .else_ready(else_ready),
        .cond_valid(cond_valid), .cond_in(cond_in), .cond_ready(cond_ready),
        .out_valid(out_valid), .out_ready(out_ready),
        .out_data(out_data), .out_cond(out_cond)
`ifdef DEMOD_MERGE_STATS_EN
        , .stat_clr(stat_clr), .stat_if_cnt(stat_if_cnt), .stat_else_cnt(stat_else_cnt)
`endif
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_chk++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s got=%h exp=%h", tag, got, exp);
        end
    endtask

    task automatic tick;
        @(posedge clk);
        #1;
    endtask

    function automatic logic [DW-1:0] pk(input int hi, input int lo);
        return {32'(hi), 32'(lo)};
    endfunction

    // back-pressure stream entry j: cond = j odd
    function automatic logic [DW-1:0] bp_if(input int j);   return pk(j + 200, j);      endfunction
    function automatic logic [DW-1:0] bp_else(input int j); return pk(j + 300, j + 50); endfunction
    function automatic logic [DW-1:0] bp_exp(input int j);
        return (j % 2 == 1) ? bp_if(j) : bp_else(j);
    endfunction

    initial begin
        int vals [4];
        int idx;
        int stale;
        logic pushed;

        // ---------------- reset ----------------
        #1;
        tick(); tick(); tick();
        chk("rst_if_ready",   {63'd0, if_ready},   64'd0);
        chk("rst_else_ready", {63'd0, else_ready}, 64'd0);
        chk("rst_cond_ready", {63'd0, cond_ready}, 64'd0);
        chk("rst_out_valid",  {63'd0, out_valid},  64'd0);
        chk("rst_out_data",   out_data,            64'd0);
        chk("rst_out_cond",   {63'd0, out_cond},   64'd0);
        reset = 1'b0;
        #1;
        chk("rel_ready", {61'd0, if_ready, else_ready, cond_ready}, 64'd7);

        // ---------------- basic select ----------------
        out_ready = 1'b1;
        if_valid = 1; else_valid = 1; cond_valid = 1;
        if_data = pk(2, 1); else_data = pk(4, 3); cond_in = 1'b1;
        tick();
        if_valid = 0; else_valid = 0; cond_valid = 0;
        chk("sel1_not_yet", {63'd0, out_valid}, 64'd0);
        tick();
        chk("sel1_valid", {63'd0, out_valid}, 64'd1);
        chk("sel1_data",  out_data,           pk(2, 1));
        chk("sel1_cond",  {63'd0, out_cond},  64'd1);
        if_valid = 1; else_valid = 1; cond_valid = 1; cond_in = 1'b0;
        tick();
        if_valid = 0; else_valid = 0; cond_valid = 0;
        chk("sel0_gap", {63'd0, out_valid}, 64'd0);
        tick();
        chk("sel0_valid", {63'd0, out_valid}, 64'd1);
        chk("sel0_data",  out_data,           pk(4, 3));
        chk("sel0_cond",  {63'd0, out_cond},  64'd0);
        tick();
        chk("sel_drained", {63'd0, out_valid}, 64'd0);

        // ---------------- skew ----------------
        for (int i = 1; i <= 4; i++) begin
            if_valid = 1; else_valid = 1;
            if_data = pk(i + 100, i); else_data = pk(i + 110, i + 10);
            tick();
        end
        chk("skew_if_full",   {63'd0, if_ready},   64'd0);
        chk("skew_else_full", {63'd0, else_ready}, 64'd0);
        chk("skew_no_fire",   {63'd0, out_valid},  64'd0);
        if_data = pk(999, 99);  // must be refused while full
        tick();
        if_valid = 0; else_valid = 0;
        vals[0] = 1; vals[1] = 12; vals[2] = 3; vals[3] = 14;
        for (int i = 0; i <= 4; i++) begin
            cond_valid = (i < 4);
            cond_in = (i % 2 == 0);
            tick();
            if (i >= 1) begin
                chk($sformatf("skew_v%0d", i - 1), {63'd0, out_valid}, 64'd1);
                chk($sformatf("skew_d%0d", i - 1), out_data, pk(vals[i-1] + 100, vals[i-1]));
            end
        end
        cond_valid = 0;
        chk("skew_if_ready_back", {63'd0, if_ready}, 64'd1);
        tick();
        chk("skew_drained", {63'd0, out_valid}, 64'd0);

        // ---------------- back-pressure ----------------
        out_ready = 1'b0;
        idx = 0;
        if_valid = 1; else_valid = 1; cond_valid = 1;
        for (int i = 0; i < 10; i++) begin
            if_data = bp_if(idx); else_data = bp_else(idx); cond_in = (idx % 2 == 1);
            pushed = if_ready;
            tick();
            if (pushed) idx++;
            if (i >= 1) chk($sformatf("bp_hold%0d", i), out_data, bp_exp(0));
        end
        chk("bp_accepted", 64'(idx), 64'd5);
        chk("bp_all_full", {61'd0, if_ready, else_ready, cond_ready}, 64'd0);
        if_valid = 0; else_valid = 0; cond_valid = 0;
        out_ready = 1'b1;
        for (int j = 0; j < 5; j++) begin
            chk($sformatf("bp_drain_v%0d", j), {63'd0, out_valid}, 64'd1);
            chk($sformatf("bp_drain_d%0d", j), out_data, bp_exp(j));
            tick();
        end
        chk("bp_empty", {63'd0, out_valid}, 64'd0);

        // ---------------- reset mid-stream ----------------
        out_ready = 1'b0;
        if_valid = 1; else_valid = 1; cond_valid = 1; cond_in = 1'b1;
        for (int i = 0; i < 4; i++) begin
            if_data = pk(700 + i, 600 + i); else_data = pk(800 + i, 500 + i);
            tick();
        end
        if_valid = 0; else_valid = 0; cond_valid = 0;
        chk("mid_pre_valid", {63'd0, out_valid}, 64'd1);
        reset = 1'b1;
        tick(); tick();
        reset = 1'b0;
        #1;
        chk("mid_valid", {63'd0, out_valid}, 64'd0);
        chk("mid_data",  out_data,           64'd0);
        out_ready = 1'b1;
        stale = 0;
        for (int i = 0; i < 6; i++) begin
            tick();
            if (out_valid) stale++;
        end
        chk("mid_no_stale", 64'(stale), 64'd0);
        if_valid = 1; else_valid = 1; cond_valid = 1;
        if_data = pk(42, 41); else_data = pk(44, 43); cond_in = 1'b0;
        tick();
        if_valid = 0; else_valid = 0; cond_valid = 0;
        tick();
        chk("mid_fresh_v", {63'd0, out_valid}, 64'd1);
        chk("mid_fresh_d", out_data,           pk(44, 43));
        tick();

`ifdef DEMOD_MERGE_STATS_EN
        // ---------------- stats ----------------
        stat_clr = 1'b1;
        tick();
        stat_clr = 1'b0;
        for (int i = 0; i < 5; i++) begin
            if_valid = 1; else_valid = 1; cond_valid = 1;
            if_data = pk(i, i); else_data = pk(i + 9, i + 9);
            cond_in = (i == 0 || i == 1 || i == 3);
            tick();
        end
        if_valid = 0; else_valid = 0; cond_valid = 0;
        tick();
        chk("stat_if",   64'(stat_if_cnt),   64'd3);
        chk("stat_else", 64'(stat_else_cnt), 64'd2);
        stat_clr = 1'b1;
        tick();
        stat_clr = 1'b0;
        chk("stat_clr_if",   64'(stat_if_cnt),   64'd0);
        chk("stat_clr_else", 64'(stat_else_cnt), 64'd0);
`endif

        $display("Result: errors=%0d of %0d checks", n_err, n_chk);
        $finish;
    end
endmodule
